// File: rtl/upe_mul_seq.sv
// Sequential WIDTHxWIDTH signed/unsigned multiplier built around a single 16x16 limb multiplier.
// Operands are reduced to magnitudes on accept and the sign is restored on the accumulated product.
module upe_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               in_signed_i,
  input  logic [WIDTH-1:0]   in_a_i,
  input  logic [WIDTH-1:0]   in_b_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] out_p_o
);

  localparam int N  = WIDTH / 16;
  localparam int PW = 2 * WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] LAST = 2'(N - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       i_q, i_d, j_q, j_d;
  logic [WIDTH-1:0] aMag_q, aMag_d, bMag_q, bMag_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    p_q, p_d;
  logic             outValid_q, outValid_d;

  logic             aNeg, bNeg;
  logic [15:0]      aLimb, bLimb;
  logic [31:0]      limbProd;
  logic [6:0]       shamt;
  logic [PW-1:0]    partial;

  assign aNeg = in_signed_i & in_a_i[WIDTH-1];
  assign bNeg = in_signed_i & in_b_i[WIDTH-1];

  // Limb pair (i, j) lands at bit 16*(i+j) of the accumulator.
  assign aLimb    = 16'(aMag_q >> {i_q, 4'b0000});
  assign bLimb    = 16'(bMag_q >> {j_q, 4'b0000});
  assign limbProd = 32'(aLimb) * 32'(bLimb);
  assign shamt    = {(3'(i_q) + 3'(j_q)), 4'b0000};
  assign partial  = PW'(limbProd) << shamt;

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    aMag_d     = aMag_q;
    bMag_d     = bMag_q;
    neg_d      = neg_q;
    acc_d      = acc_q;
    p_d        = p_q;
    outValid_d = outValid_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          aMag_d  = aNeg ? (~in_a_i + WIDTH'(1)) : in_a_i;
          bMag_d  = bNeg ? (~in_b_i + WIDTH'(1)) : in_b_i;
          neg_d   = in_signed_i & (in_a_i[WIDTH-1] ^ in_b_i[WIDTH-1]);
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = acc_q + partial;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d     = '0;
            state_d = FIX;
          end else begin
            i_d = i_q + 2'd1;
          end
        end else begin
          j_d = j_q + 2'd1;
        end
      end
      FIX: begin
        p_d        = neg_q ? (~acc_q + PW'(1)) : acc_q;
        outValid_d = 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready_i) begin
          outValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      aMag_q     <= '0;
      bMag_q     <= '0;
      neg_q      <= 1'b0;
      acc_q      <= '0;
      p_q        <= '0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      aMag_q     <= aMag_d;
      bMag_q     <= bMag_d;
      neg_q      <= neg_d;
      acc_q      <= acc_d;
      p_q        <= p_d;
      outValid_q <= outValid_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = outValid_q;
  assign out_p_o     = p_q;

endmodule

// File: tb/tb_upe_mul_seq.sv
// Bench for upe_mul_seq at WIDTH 16, 32 and 64: directed vectors, handshake/reset corner cases
// and randomized operands compared against an arithmetic reference product.
module tb_upe_mul_seq;

  logic         clk = 1'b0;
  logic         rstN;
  logic [2:0]   inValid;
  logic [2:0]   outReady;
  logic         inReady0, inReady1, inReady2;
  logic         outValid0, outValid1, outValid2;
  logic         inSigned;
  logic [63:0]  inA, inB;
  logic [31:0]  p16;
  logic [63:0]  p32;
  logic [127:0] p64;
  int           checks = 0;
  int           passes = 0;

  typedef struct {
    int           sel;
    logic [63:0]  a;
    logic [63:0]  b;
    logic         s;
    logic [127:0] exp;
    string        name;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  upe_mul_seq #(.WIDTH(16)) dut16 (
    .clk_i(clk), .rst_ni(rstN), .in_valid_i(inValid[0]), .in_ready_o(inReady0),
    .in_signed_i(inSigned), .in_a_i(inA[15:0]), .in_b_i(inB[15:0]),
    .out_valid_o(outValid0), .out_ready_i(outReady[0]), .out_p_o(p16));

  upe_mul_seq #(.WIDTH(32)) dut32 (
    .clk_i(clk), .rst_ni(rstN), .in_valid_i(inValid[1]), .in_ready_o(inReady1),
    .in_signed_i(inSigned), .in_a_i(inA[31:0]), .in_b_i(inB[31:0]),
    .out_valid_o(outValid1), .out_ready_i(outReady[1]), .out_p_o(p32));

  upe_mul_seq #(.WIDTH(64)) dut64 (
    .clk_i(clk), .rst_ni(rstN), .in_valid_i(inValid[2]), .in_ready_o(inReady2),
    .in_signed_i(inSigned), .in_a_i(inA), .in_b_i(inB),
    .out_valid_o(outValid2), .out_ready_i(outReady[2]), .out_p_o(p64));

  function automatic int widthOf(int sel);
    return (sel == 0) ? 16 : (sel == 1) ? 32 : 64;
  endfunction

  function automatic int expLat(int sel);
    int n;
    n = widthOf(sel) / 16;
    return n * n + 1;
  endfunction

  function automatic logic [127:0] getP(int sel);
    case (sel)
      0:       return 128'(p16);
      1:       return 128'(p32);
      default: return p64;
    endcase
  endfunction

  function automatic logic getReady(int sel);
    return (sel == 0) ? inReady0 : (sel == 1) ? inReady1 : inReady2;
  endfunction

  function automatic logic getValid(int sel);
    return (sel == 0) ? outValid0 : (sel == 1) ? outValid1 : outValid2;
  endfunction

  // Operands interpreted as w-bit integers, multiplied exactly, product kept modulo 2^(2w).
  function automatic logic [127:0] refMul(int w, logic [63:0] a, logic [63:0] b, logic s);
    logic [127:0]        wmask, pmask;
    logic signed [127:0] sa, sb;
    wmask = (128'(1) << w) - 128'(1);
    pmask = (w == 64) ? '1 : ((128'(1) << (2 * w)) - 128'(1));
    sa = $signed(128'(a) & wmask);
    sb = $signed(128'(b) & wmask);
    if (s && a[w-1]) sa = sa - $signed(128'(1) << w);
    if (s && b[w-1]) sb = sb - $signed(128'(1) << w);
    return 128'(sa * sb) & pmask;
  endfunction

  function automatic logic [63:0] pickOperand(int w);
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return (w == 64) ? '1 : ((64'(1) << w) - 64'(1));
      2:       return 64'(1) << (w - 1);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic addVec(input int sel, input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic [127:0] exp, input string name);
    vec_t v;
    v.sel = sel; v.a = a; v.b = b; v.s = s; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  // Called at a negedge; returns at the negedge where out_valid is first seen.
  task automatic applyStimulus(input int sel, input logic [63:0] a, input logic [63:0] b,
                               input logic s, input bit scramble,
                               output logic [127:0] p, output int lat);
    int guard;
    guard = 0;
    while (!getReady(sel) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    inA = a; inB = b; inSigned = s; inValid[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid[sel] = 1'b0;
    lat = 0;
    while (!getValid(sel) && lat < 100) begin
      if (scramble) begin
        inA = {$urandom, $urandom};
        inB = {$urandom, $urandom};
        inSigned = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    p = getP(sel);
  endtask

  task automatic finishOp(input int sel);
    outReady[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady[sel] = 1'b0;
  endtask

  task automatic runChecked(input int sel, input logic [63:0] a, input logic [63:0] b,
                            input logic s, input bit scramble, input string name);
    logic [127:0] p;
    int           lat;
    applyStimulus(sel, a, b, s, scramble, p, lat);
    checkOutput(name, p, refMul(widthOf(sel), a, b, s));
    checkOutput({name, "_lat"}, 128'(lat), 128'(expLat(sel)));
    finishOp(sel);
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] p;
    int           lat;

    rstN = 1'b0; inValid = '0; outReady = '0; inSigned = 1'b0; inA = '0; inB = '0;

    addVec(1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 128'hFFFF_FFFE_0000_0001, "u32_max");
    addVec(1, 64'hFFFF_FFFE, 64'h3,         1'b1, 128'hFFFF_FFFF_FFFF_FFFA, "s32_m2x3");
    addVec(1, 64'h8000_0000, 64'h8000_0000, 1'b1, 128'h4000_0000_0000_0000, "s32_minsq");
    addVec(1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 128'h1,                   "s32_m1sq");
    addVec(1, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 128'h8000_0000,           "s32_minxm1");
    addVec(1, 64'h0,         64'hFFFF_FFFF, 1'b1, 128'h0,                   "s32_zero");
    addVec(0, 64'h8000,      64'h8000,      1'b1, 128'h4000_0000,           "s16_minsq");
    addVec(0, 64'hFFFF,      64'hFFFF,      1'b0, 128'hFFFE_0001,           "u16_max");
    addVec(0, 64'h8000,      64'h7FFF,      1'b1, 128'hC000_8000,           "s16_minxmax");
    addVec(2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
           128'h4000_0000_0000_0000_0000_0000_0000_0000, "s64_minsq");
    addVec(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1'b0,
           128'h1_FFFF_FFFF_FFFF_FFFE, "u64_maxx2");
    addVec(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'h1, "s64_m1sq");

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int sel = 0; sel < 3; sel++) begin
      checkOutput("rst_ready", 128'(getReady(sel)), 128'(1));
      checkOutput("rst_valid", 128'(getValid(sel)), 128'(0));
      checkOutput("rst_p", getP(sel), 128'(0));
    end
    rstN = 1'b1;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].sel, vecs[k].a, vecs[k].b, vecs[k].s, 1'b0, p, lat);
      checkOutput(vecs[k].name, p, vecs[k].exp);
      checkOutput({vecs[k].name, "_lat"}, 128'(lat), 128'(expLat(vecs[k].sel)));
      finishOp(vecs[k].sel);
    end

    // Backpressure: result and flags must hold while the consumer stalls.
    applyStimulus(1, 64'h1234_5678, 64'h9ABC_DEF0, 1'b0, 1'b0, p, lat);
    checkOutput("bp_result", p, refMul(32, 64'h1234_5678, 64'h9ABC_DEF0, 1'b0));
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp_p_hold", getP(1), p);
      checkOutput("bp_valid_ready", 128'({getValid(1), getReady(1)}), 128'(2'b10));
    end
    outReady[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady[1] = 1'b0;
    checkOutput("bp_release", 128'({getValid(1), getReady(1)}), 128'(2'b01));
    checkOutput("bp_p_retained", getP(1), p);

    // Reset during the second MUL cycle discards the operation.
    inA = 64'd5; inB = 64'd9; inSigned = 1'b0; inValid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    checkOutput("midrst_ready", 128'(getReady(1)), 128'(1));
    checkOutput("midrst_valid", 128'(getValid(1)), 128'(0));
    checkOutput("midrst_p", getP(1), 128'(0));
    repeat (8) @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_no_result", 128'(getValid(1)), 128'(0));
    applyStimulus(1, 64'd7, 64'd6, 1'b0, 1'b0, p, lat);
    checkOutput("after_rst_7x6", p, 128'd42);
    finishOp(1);

    // Inputs wiggle every cycle after accept; only the accepted values count.
    runChecked(1, 64'hDEAD_BEEF, 64'h8000_0001, 1'b1, 1'b1, "scramble32");
    runChecked(2, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, "scramble64");
    runChecked(0, 64'hBEEF, 64'h1234, 1'b0, 1'b1, "scramble16");

    for (int k = 0; k < 1000; k++)
      runChecked(0, pickOperand(16), pickOperand(16), 1'($urandom_range(0, 1)), 1'b0, "rand16");
    for (int k = 0; k < 200; k++)
      runChecked(1, pickOperand(32), pickOperand(32), 1'($urandom_range(0, 1)), 1'b0, "rand32");
    for (int k = 0; k < 1000; k++)
      runChecked(2, pickOperand(64), pickOperand(64), 1'($urandom_range(0, 1)), 1'b0, "rand64");

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
